// File: rtl/dcache_coherence_port_if.sv
`default_nettype none
// ============================================================================
// Module   : dcache_coherence_port_if
// Brief    : Cache, snoop and memory-controller signals of one core's port
// Revision : 1.0  initial release
// ============================================================================
interface dcache_coherence_port_if #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
);
  logic              miss_req;
  logic [ADDR_W-1:0] miss_addr;
  logic              miss_rdx;
  logic              evict_req;
  logic [ADDR_W-1:0] evict_addr;
  logic [WORD_W-1:0] evict_w0;
  logic [WORD_W-1:0] evict_w1;
  logic              miss_done;
  logic [WORD_W-1:0] fill_w0;
  logic [WORD_W-1:0] fill_w1;
  logic              evict_done;
  logic [ADDR_W-1:0] snp_addr;
  logic              snp_hit;
  logic              snp_dirty;
  logic [WORD_W-1:0] snp_w0;
  logic [WORD_W-1:0] snp_w1;
  logic              snp_inv;
  logic              snp_clean;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              dwait;
  logic [WORD_W-1:0] dload;
  logic              cctrans;
  logic              ccwrite;
  logic              ccwait;
  logic              ccinv;
  logic [ADDR_W-1:0] ccsnoopaddr;

  modport master (
    input  miss_req, miss_addr, miss_rdx, evict_req, evict_addr, evict_w0, evict_w1,
           snp_hit, snp_dirty, snp_w0, snp_w1, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    output miss_done, fill_w0, fill_w1, evict_done, snp_addr, snp_inv, snp_clean,
           dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );

  modport slave (
    output miss_req, miss_addr, miss_rdx, evict_req, evict_addr, evict_w0, evict_w1,
           snp_hit, snp_dirty, snp_w0, snp_w1, dwait, dload, ccwait, ccinv, ccsnoopaddr,
    input  miss_done, fill_w0, fill_w1, evict_done, snp_addr, snp_inv, snp_clean,
           dREN, dWEN, daddr, dstore, cctrans, ccwrite
  );
endinterface
`default_nettype wire

// File: rtl/dcache_coherence_port.sv
`default_nettype none
// ============================================================================
// Module   : dcache_coherence_port
// Brief    : Per-core dcache bus front end: miss fill, victim writeback, snoops.
//            Optional DCP_SNOOP_STATS_EN adds snoop hit / supply counters.
// Revision : 1.0  initial release
// ============================================================================
module dcache_coherence_port #(
  parameter int CPUID  = 0,
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32
) (
  input  logic CLK,
  input  logic RST,
`ifdef DCP_SNOOP_STATS_EN
  output logic [15:0] snp_hit_cnt,
  output logic [15:0] snp_supply_cnt,
`endif
  dcache_coherence_port_if.master bus
);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    SNP   = 4'd1,
    SWB0  = 4'd2,
    SWB1  = 4'd3,
    EWB0  = 4'd4,
    EWB1  = 4'd5,
    FILL0 = 4'd6,
    FILL1 = 4'd7,
    DONE  = 4'd8
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [ADDR_W-4:0] r_blk;
  logic              r_rdx;
  logic              r_inv;
  logic [WORD_W-1:0] r_sw0;
  logic [WORD_W-1:0] r_sw1;
  logic [WORD_W-1:0] r_fill0;
  logic [WORD_W-1:0] r_fill1;
  logic              w_acc;
  logic              w_unused;

  assign w_acc       = !bus.dwait;
  assign w_unused    = ^{bus.miss_addr[2:0], bus.evict_addr[2:0], bus.ccsnoopaddr[2:0]};
  assign bus.fill_w0 = r_fill0;
  assign bus.fill_w1 = r_fill1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_state <= IDLE;
      r_blk   <= '0;
      r_rdx   <= 1'b0;
      r_inv   <= 1'b0;
      r_sw0   <= '0;
      r_sw1   <= '0;
      r_fill0 <= '0;
      r_fill1 <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        IDLE: begin
          if (!bus.ccwait) begin
            if (bus.evict_req) begin
              r_blk <= bus.evict_addr[ADDR_W-1:3];
            end else if (bus.miss_req) begin
              r_blk <= bus.miss_addr[ADDR_W-1:3];
              r_rdx <= bus.miss_rdx;
            end
          end
        end
        // Snooped line is captured here so the cache may keep working on its arrays.
        SNP: begin
          r_blk <= bus.ccsnoopaddr[ADDR_W-1:3];
          r_inv <= bus.ccinv;
          r_sw0 <= bus.snp_w0;
          r_sw1 <= bus.snp_w1;
        end
        FILL0: if (w_acc) r_fill0 <= bus.dload;
        FILL1: if (w_acc) r_fill1 <= bus.dload;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next         = r_state;
    bus.miss_done  = 1'b0;
    bus.evict_done = 1'b0;
    bus.snp_addr   = '0;
    bus.snp_inv    = 1'b0;
    bus.snp_clean  = 1'b0;
    bus.dREN       = 1'b0;
    bus.dWEN       = 1'b0;
    bus.daddr      = '0;
    bus.dstore     = '0;
    bus.cctrans    = 1'b0;
    bus.ccwrite    = 1'b0;
    case (r_state)
      IDLE: begin
        if (bus.ccwait)         w_next = SNP;
        else if (bus.evict_req) w_next = EWB0;
        else if (bus.miss_req)  w_next = FILL0;
      end
      SNP: begin
        bus.snp_addr = {bus.ccsnoopaddr[ADDR_W-1:3], 3'b000};
        if (bus.snp_hit && bus.snp_dirty) begin
          w_next = SWB0;
        end else begin
          bus.snp_inv = bus.snp_hit && bus.ccinv;
          w_next      = IDLE;
        end
      end
      SWB0, SWB1: begin
        bus.dWEN    = 1'b1;
        bus.ccwrite = 1'b1;
        bus.daddr   = {r_blk, (r_state == SWB1), 2'b00};
        bus.dstore  = (r_state == SWB1) ? r_sw1 : r_sw0;
        if (w_acc) begin
          if (r_state == SWB0) begin
            w_next = SWB1;
          end else begin
            bus.snp_inv   = r_inv;
            bus.snp_clean = !r_inv;
            w_next        = IDLE;
          end
        end
      end
      EWB0, EWB1: begin
        bus.dWEN   = 1'b1;
        bus.daddr  = {r_blk, (r_state == EWB1), 2'b00};
        bus.dstore = (r_state == EWB1) ? bus.evict_w1 : bus.evict_w0;
        if (w_acc) begin
          bus.evict_done = (r_state == EWB1);
          w_next         = (r_state == EWB1) ? IDLE : EWB1;
        end
      end
      FILL0, FILL1: begin
        bus.dREN    = 1'b1;
        bus.cctrans = 1'b1;
        bus.ccwrite = r_rdx;
        bus.daddr   = {r_blk, (r_state == FILL1), 2'b00};
        if (w_acc) w_next = (r_state == FILL1) ? DONE : FILL1;
      end
      DONE: begin
        bus.miss_done = 1'b1;
        w_next        = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

`ifdef DCP_SNOOP_STATS_EN
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      snp_hit_cnt    <= '0;
      snp_supply_cnt <= '0;
    end else begin
      if (r_state == SNP && bus.snp_hit && snp_hit_cnt != 16'hFFFF)
        snp_hit_cnt <= snp_hit_cnt + 16'd1;
      if (r_state == SWB1 && w_acc && snp_supply_cnt != 16'hFFFF)
        snp_supply_cnt <= snp_supply_cnt + 16'd1;
    end
  end
`else
  // Snoop statistics not built: no counter state exists.
`endif

`ifndef SYNTHESIS
  a_miss_held: assert property (@(posedge CLK) disable iff (RST)
      (r_state == FILL0 || r_state == FILL1) |-> bus.miss_req)
    else $error("dcache_coherence_port cpu%0d: miss_req dropped during fill", CPUID);
`endif

endmodule
`default_nettype wire

// File: tb/tb_dcache_coherence_port.sv
`default_nettype none
// ============================================================================
// Module   : tb_dcache_coherence_port
// Brief    : Randomized bench with a transaction-level scoreboard of bus words
// Revision : 1.0  initial release
// ============================================================================
module tb_dcache_coherence_port;

  typedef struct packed {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic        tr;
    logic        cw;
  } word_t;

  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  dcache_coherence_port_if #(.ADDR_W(32), .WORD_W(32)) bus ();

`ifdef DCP_SNOOP_STATS_EN
  logic [15:0] hit_cnt;
  logic [15:0] sup_cnt;
`endif

  dcache_coherence_port #(.CPUID(0), .ADDR_W(32), .WORD_W(32)) dut (
    .CLK            (CLK),
    .RST            (RST),
`ifdef DCP_SNOOP_STATS_EN
    .snp_hit_cnt    (hit_cnt),
    .snp_supply_cnt (sup_cnt),
`endif
    .bus            (bus)
  );

  int n_chk = 0, n_pass = 0;
  int cyc = 0, n_md = 0, n_ed = 0, n_inv = 0, n_cln = 0, md_cyc = 0, ed_obs = 0;
  int wait_mode = 0, wait_n = 0, wcnt = 0, exp_hit = 0, exp_sup = 0, lat;
  logic [31:0] f0, f1, h_addr, h_data;
  logic [1:0]  h_en;
  bit          held = 1'b0;
  word_t       obs_q[$];
  word_t       exp_q[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'hAAAA_0100;
  endfunction

  // One bus cycle as seen by the memory controller: answer, then observe.
  task automatic step();
    @(negedge CLK);
    cyc++;
    bus.dload = mem(bus.daddr);
    if (bus.dREN || bus.dWEN) begin
      case (wait_mode)
        0:       bus.dwait = 1'b0;
        1:       bus.dwait = (wcnt < wait_n);
        default: bus.dwait = ($urandom_range(0, 2) == 0);
      endcase
      wcnt = bus.dwait ? wcnt + 1 : 0;
    end else begin
      bus.dwait = 1'($urandom_range(0, 1));
    end
    #1;
    if (held) begin
      chk("hold_en", 64'({bus.dREN, bus.dWEN}), 64'(h_en));
      chk("hold_addr", 64'(bus.daddr), 64'(h_addr));
      if (h_en[0]) chk("hold_data", 64'(bus.dstore), 64'(h_data));
    end
    if (bus.dREN || bus.dWEN) begin
      if (bus.dREN && bus.dWEN) chk("one_enable", 64'(2'b11), 64'(2'b01));
      if (!bus.dwait)
        obs_q.push_back('{bus.dWEN, bus.daddr, bus.dWEN ? bus.dstore : bus.dload,
                          bus.cctrans, bus.ccwrite});
    end
    held   = (bus.dREN || bus.dWEN) && bus.dwait;
    h_en   = {bus.dREN, bus.dWEN};
    h_addr = bus.daddr;
    h_data = bus.dstore;
    if (bus.miss_done) begin
      n_md++;
      md_cyc = cyc;
      f0 = bus.fill_w0;
      f1 = bus.fill_w1;
      chk("done_quiet", 64'({bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite}), 64'(0));
    end
    if (bus.evict_done) begin
      n_ed++;
      ed_obs = obs_q.size();
    end
    if (bus.snp_inv)   n_inv++;
    if (bus.snp_clean) n_cln++;
  endtask

  task automatic compare_q(input string tag);
    chk({tag, "_nwords"}, 64'(obs_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      chk({tag, "_kind"}, 64'({obs_q[i].wr, obs_q[i].tr, obs_q[i].cw}),
          64'({exp_q[i].wr, exp_q[i].tr, exp_q[i].cw}));
      chk({tag, "_addr"}, 64'(obs_q[i].addr), 64'(exp_q[i].addr));
      chk({tag, "_data"}, 64'(obs_q[i].data), 64'(exp_q[i].data));
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  // Requests raised together; expected order is snoop, then victim, then fill.
  task automatic txn(input bit ev, input bit ms, input bit sn, input bit hit,
                     input bit dirty, input bit inv, input bit rdx,
                     input logic [31:0] ea, input logic [31:0] ma, input logic [31:0] sa,
                     input logic [31:0] sw0, input logic [31:0] sw1, output int lt);
    logic [31:0] eb, mb, sb, ew0, ew1;
    int m0, e0, i0, c0, start;
    bit supply, fin;
    eb = ea & ~32'h7; mb = ma & ~32'h7; sb = sa & ~32'h7;
    ew0 = $urandom; ew1 = $urandom;
    supply = sn && hit && dirty;
    m0 = n_md; e0 = n_ed; i0 = n_inv; c0 = n_cln; start = cyc; lt = -1;
    if (sn) begin
      exp_hit += int'(hit);
      if (supply) begin
        exp_sup++;
        exp_q.push_back('{1'b1, sb, sw0, 1'b0, 1'b1});
        exp_q.push_back('{1'b1, sb | 32'h4, sw1, 1'b0, 1'b1});
      end
      bus.snp_hit = hit; bus.snp_dirty = dirty; bus.snp_w0 = sw0; bus.snp_w1 = sw1;
      bus.ccinv = inv; bus.ccsnoopaddr = sb | 32'($urandom_range(0, 7)); bus.ccwait = 1'b1;
    end
    if (ev) begin
      exp_q.push_back('{1'b1, eb, ew0, 1'b0, 1'b0});
      exp_q.push_back('{1'b1, eb | 32'h4, ew1, 1'b0, 1'b0});
      bus.evict_addr = eb | 32'($urandom_range(0, 7));
      bus.evict_w0 = ew0; bus.evict_w1 = ew1; bus.evict_req = 1'b1;
    end
    if (ms) begin
      exp_q.push_back('{1'b0, mb, mem(mb), 1'b1, rdx});
      exp_q.push_back('{1'b0, mb | 32'h4, mem(mb | 32'h4), 1'b1, rdx});
      bus.miss_addr = mb | 32'($urandom_range(0, 7)); bus.miss_rdx = rdx; bus.miss_req = 1'b1;
    end
    for (int i = 0; i < 400; i++) begin
      step();
      if (i == 0 && sn) begin
        chk("snp_addr", 64'(bus.snp_addr), 64'(sb));
        bus.ccwait = 1'b0;
      end
      if (i == 1 && sn) begin
        bus.snp_w0 = ~sw0;
        bus.snp_w1 = ~sw1;
      end
      if (n_ed != e0) bus.evict_req = 1'b0;
      if (n_md != m0 && bus.miss_req) begin
        bus.miss_req = 1'b0;
        lt = md_cyc - start;
      end
      fin = (i >= 2) && (!ev || n_ed != e0) && (!ms || n_md != m0) &&
            (!supply || (n_inv + n_cln) != (i0 + c0));
      if (fin) break;
    end
    bus.evict_req = 1'b0; bus.miss_req = 1'b0; bus.ccwait = 1'b0;
    bus.snp_hit = 1'b0; bus.snp_dirty = 1'b0;
    step(); step();
    chk("miss_done_cnt", 64'(n_md - m0), 64'(ms));
    chk("evict_done_cnt", 64'(n_ed - e0), 64'(ev));
    chk("snp_inv_cnt", 64'(n_inv - i0), 64'(sn && hit && inv));
    chk("snp_clean_cnt", 64'(n_cln - c0), 64'(supply && !inv));
    if (ms) begin
      chk("fill_w0", 64'(f0), 64'(mem(mb)));
      chk("fill_w1", 64'(f1), 64'(mem(mb | 32'h4)));
    end
    if (ev) chk("evict_done_order", 64'(ed_obs), 64'(supply ? 4 : 2));
    compare_q("txn");
  endtask

  task automatic reset_in_fill();
    int m0;
    wait_mode = 0; m0 = n_md;
    bus.miss_addr = 32'h600; bus.miss_rdx = 1'b0; bus.miss_req = 1'b1;
    step(); step();
    chk("pre_rst_fill1", 64'({bus.dREN, bus.daddr}), 64'({1'b1, 32'h604}));
    RST = 1'b1;
    #1;
    chk("rst_mid_ctl", 64'({bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite, bus.miss_done}), 64'(0));
    chk("rst_mid_daddr", 64'(bus.daddr), 64'(0));
    chk("rst_mid_fill", {bus.fill_w0, bus.fill_w1}, 64'(0));
    bus.miss_req = 1'b0; held = 1'b0; obs_q.delete();
    exp_hit = 0; exp_sup = 0;
    @(negedge CLK);
    RST = 1'b0;
    repeat (6) step();
    chk("rst_no_done", 64'(n_md - m0), 64'(0));
    chk("rst_no_words", 64'(obs_q.size()), 64'(0));
    obs_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] kind;
    bus.miss_req = 0; bus.miss_addr = 0; bus.miss_rdx = 0;
    bus.evict_req = 0; bus.evict_addr = 0; bus.evict_w0 = 0; bus.evict_w1 = 0;
    bus.snp_hit = 0; bus.snp_dirty = 0; bus.snp_w0 = 0; bus.snp_w1 = 0;
    bus.dwait = 1; bus.dload = 0; bus.ccwait = 0; bus.ccinv = 0; bus.ccsnoopaddr = 0;
    repeat (3) @(negedge CLK);
    chk("rst_hold_ctl", 64'({bus.dREN, bus.dWEN, bus.cctrans, bus.ccwrite, bus.miss_done,
                             bus.evict_done, bus.snp_inv, bus.snp_clean}), 64'(0));
    RST = 1'b0;
    step();
    chk("rst_daddr", 64'(bus.daddr), 64'(0));
    chk("rst_dstore", 64'(bus.dstore), 64'(0));
    chk("rst_snp_addr", 64'(bus.snp_addr), 64'(0));
    chk("rst_fill", {bus.fill_w0, bus.fill_w1}, 64'(0));

    wait_mode = 0;
    txn(0, 1, 0, 0, 0, 0, 0, 0, 32'h100, 0, 0, 0, lat);
    chk("read_miss_latency", 64'(lat), 64'(3));
    chk("read_miss_fills", {f0, f1}, {32'hAAAA_0000, 32'hAAAA_0004});

    wait_mode = 1; wait_n = 4;
    txn(0, 1, 0, 0, 0, 0, 1, 0, 32'h200, 0, 0, 0, lat);
    chk("rdx_miss_latency", 64'(lat), 64'(11));

    wait_mode = 0;
    txn(0, 0, 1, 1, 1, 1, 0, 0, 0, 32'h300, 32'h11, 32'h22, lat);
    wait_mode = 2;
    txn(0, 0, 1, 1, 1, 0, 0, 0, 0, 32'h308, 32'h33, 32'h44, lat);
    txn(0, 0, 1, 1, 0, 0, 0, 0, 0, 32'h310, 32'h55, 32'h66, lat);
    txn(0, 0, 1, 1, 0, 1, 0, 0, 0, 32'h318, 32'h77, 32'h88, lat);
    txn(0, 0, 1, 0, 1, 1, 0, 0, 0, 32'h320, 32'h99, 32'hAA, lat);

    wait_mode = 0;
    txn(1, 1, 0, 0, 0, 0, 0, 32'h400, 32'h500, 0, 0, 0, lat);
    wait_mode = 2;
    txn(0, 1, 1, 1, 1, 1, 1, 0, 32'h700, 32'h708, 32'hBEEF, 32'hCAFE, lat);

    reset_in_fill();

    for (int n = 0; n < 40; n++) begin
      wait_mode = $urandom_range(0, 2);
      wait_n    = $urandom_range(0, 3);
      kind      = 3'($urandom_range(1, 7));
      txn(kind[0], kind[1], kind[2], 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8, $urandom & 32'hFFFF_FFF8,
          $urandom, $urandom, lat);
    end

`ifdef DCP_SNOOP_STATS_EN
    chk("stat_hit_cnt", 64'(hit_cnt), 64'(exp_hit));
    chk("stat_supply_cnt", 64'(sup_cnt), 64'(exp_sup));
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
